// File: rtl/sync_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
// Holds the request FSM state encoding used by the source-side requester.
`timescale 1ns/1ps

package sync_pkg;

  // Request-side handshake states.
  typedef enum logic [1:0] {
    SYNC_ST_IDLE   = 2'd0,
    SYNC_ST_REQ    = 2'd1,
    SYNC_ST_ACK_HI = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sync_level2level.sv
// Multi-flop level synchronizer: carries a slowly changing level into the clk
// domain through a FLOP_NUM-deep chain. All flops clear to 0 on reset.
`timescale 1ns/1ps

module sync_level2level #(
  parameter int SIGNAL_WIDTH = 1,
  parameter int FLOP_NUM     = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [SIGNAL_WIDTH-1:0] sync_in,
  output logic [SIGNAL_WIDTH-1:0] sync_out
);

  logic [SIGNAL_WIDTH-1:0] chain_r [FLOP_NUM];

  // Shift the asynchronous level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < FLOP_NUM; i++) begin
        chain_r[i] <= {SIGNAL_WIDTH{1'b0}};
      end
    end else begin
      chain_r[0] <= sync_in;
      for (int i = 1; i < FLOP_NUM; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign sync_out = chain_r[FLOP_NUM-1];

endmodule

// File: rtl/sync_pulse2level_req.sv
// Source side of a 4-phase req/ack CDC handshake. Event pulses are counted as
// pending; each pending event becomes one full req_out cycle (raise, wait ack
// high, drop, wait ack low). ack_in is synchronized before the FSM sees it.
// Optional macro SYNC_REQ_TIMEOUT_EN adds a sticky handshake timeout flag
// (timeout_err port) built from a TO_WIDTH-bit wait counter.
`timescale 1ns/1ps

module sync_pulse2level_req
  import sync_pkg::*;
#(
  parameter int CNT_WIDTH    = 4,
  parameter int ACK_FLOP_NUM = 3,
  parameter int TO_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 pulse_in,
  input  logic                 ack_in,
  output logic                 req_out,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pend_cnt,
  output logic                 overflow
`ifdef SYNC_REQ_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  sync_state_t          state_r;
  logic                 req_r;
  logic                 ovf_r;
  logic [CNT_WIDTH-1:0] pend_r;

  logic ack_sync_s;
  logic start_s;
  logic commit_s;
  logic done_s;
  logic inc_s;
  logic drop_s;

  sync_level2level #(
    .SIGNAL_WIDTH (1),
    .FLOP_NUM     (ACK_FLOP_NUM)
  ) u_ack_sync (
    .clk      (clk),
    .rst_b    (rst_b),
    .sync_in  (ack_in),
    .sync_out (ack_sync_s)
  );

  // Handshake events: start a request only while ack has settled low, commit
  // an event when ack is seen high in REQ, finish when ack returns low.
  always_comb begin
    start_s  = (state_r == SYNC_ST_IDLE) && (pend_r != CNT_ZERO) && !ack_sync_s;
    commit_s = (state_r == SYNC_ST_REQ) && ack_sync_s;
    done_s   = (state_r == SYNC_ST_ACK_HI) && !ack_sync_s;
    // A commit frees a slot in the same cycle, so a full counter still accepts.
    inc_s    = pulse_in && ((pend_r != CNT_MAX) || commit_s);
    drop_s   = pulse_in && (pend_r == CNT_MAX) && !commit_s;
  end

  // Pending-event counter and registered drop indication.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend_r <= CNT_ZERO;
      ovf_r  <= 1'b0;
    end else begin
      case ({inc_s, commit_s})
        2'b10:   pend_r <= pend_r + CNT_ONE;
        2'b01:   pend_r <= pend_r - CNT_ONE;
        default: pend_r <= pend_r;
      endcase
      ovf_r <= drop_s;
    end
  end

  // Request FSM; req_out comes straight from a flop so it never glitches.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= SYNC_ST_IDLE;
      req_r   <= 1'b0;
    end else begin
      case (state_r)
        SYNC_ST_IDLE: begin
          if (start_s) begin
            state_r <= SYNC_ST_REQ;
            req_r   <= 1'b1;
          end else begin
            state_r <= SYNC_ST_IDLE;
            req_r   <= 1'b0;
          end
        end
        SYNC_ST_REQ: begin
          if (commit_s) begin
            state_r <= SYNC_ST_ACK_HI;
            req_r   <= 1'b0;
          end else begin
            state_r <= SYNC_ST_REQ;
            req_r   <= 1'b1;
          end
        end
        SYNC_ST_ACK_HI: begin
          if (done_s) begin
            state_r <= SYNC_ST_IDLE;
          end else begin
            state_r <= SYNC_ST_ACK_HI;
          end
          req_r <= 1'b0;
        end
        default: begin
          state_r <= SYNC_ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNC_REQ_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_ZERO = {TO_WIDTH{1'b0}};
  localparam logic [TO_WIDTH-1:0] TO_ONE  = TO_WIDTH'(1'b1);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = {TO_WIDTH{1'b1}};
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_MAX - TO_ONE;

  logic [TO_WIDTH-1:0] to_cnt_r;
  logic                to_err_r;

  // Count cycles spent waiting in REQ/ACK_HI; flag sticky error at all-ones.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      to_cnt_r <= TO_ZERO;
      to_err_r <= 1'b0;
    end else begin
      if (start_s || commit_s) begin
        to_cnt_r <= TO_ZERO;
      end else if ((state_r != SYNC_ST_IDLE) && !done_s && (to_cnt_r != TO_MAX)) begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      if ((state_r != SYNC_ST_IDLE) && !commit_s && !done_s && (to_cnt_r == TO_LAST)) begin
        to_err_r <= 1'b1;
      end else begin
        to_err_r <= to_err_r;
      end
    end
  end

  assign timeout_err = to_err_r;
`endif

  assign req_out  = req_r;
  assign pend_cnt = pend_r;
  assign overflow = ovf_r;
  assign busy     = (state_r != SYNC_ST_IDLE) || (pend_r != CNT_ZERO);

endmodule

// File: tb/tb_sync_pulse2level_req.sv
// Directed bench for sync_pulse2level_req. A behavioural destination
// (level-to-pulse on an unrelated 17 ns clock) returns sync_ack as ack_in.
// The main instance uses default sizing; a second instance (CNT_WIDTH=2,
// TO_WIDTH=4) covers saturation and, with SYNC_REQ_TIMEOUT_EN, the timeout.
`timescale 1ns/1ps

module tb_sync_pulse2level_req;

  localparam int CW     = 4;
  localparam int AFN    = 3;
  localparam int SAT_CW = 2;

  logic clk = 1'b0;
  logic dst_clk = 1'b0;
  logic rst_b;

  always #5 clk = ~clk;
  always #8.5 dst_clk = ~dst_clk;

  logic          pulse_m, ack_m, req_m, busy_m, ovf_m;
  logic [CW-1:0] pend_m;
  logic              pulse_s, ack_s, req_s, busy_s, ovf_s;
  logic [SAT_CW-1:0] pend_s;
`ifdef SYNC_REQ_TIMEOUT_EN
  logic terr_m, terr_s;
`endif

  logic man_en, man_ack, sat_hold;
  logic [1:0] d_s1, d_s2, d_prev;
  int   d_pulses [2];
  int   total = 0;
  int   bad = 0;
  int   rises_m = 0;
  int   ovf_cnt_m = 0;
  int   ovf_cnt_s = 0;
  logic req_prev_m = 1'b0;

  assign ack_m = man_en ? man_ack : d_s2[0];
  assign ack_s = sat_hold ? 1'b0 : d_s2[1];

  sync_pulse2level_req #(.CNT_WIDTH(CW), .ACK_FLOP_NUM(AFN), .TO_WIDTH(8)) dut (
    .clk(clk), .rst_b(rst_b), .pulse_in(pulse_m), .ack_in(ack_m),
    .req_out(req_m), .busy(busy_m), .pend_cnt(pend_m), .overflow(ovf_m)
`ifdef SYNC_REQ_TIMEOUT_EN
    , .timeout_err(terr_m)
`endif
  );

  sync_pulse2level_req #(.CNT_WIDTH(SAT_CW), .ACK_FLOP_NUM(AFN), .TO_WIDTH(4)) dut_sat (
    .clk(clk), .rst_b(rst_b), .pulse_in(pulse_s), .ack_in(ack_s),
    .req_out(req_s), .busy(busy_s), .pend_cnt(pend_s), .overflow(ovf_s)
`ifdef SYNC_REQ_TIMEOUT_EN
    , .timeout_err(terr_s)
`endif
  );

  // Destination side: 2-flop sync of req, one pulse per rising level, ack = synced req.
  always @(posedge dst_clk or negedge rst_b) begin
    if (!rst_b) begin
      d_s1   <= 2'b00;
      d_s2   <= 2'b00;
      d_prev <= 2'b00;
    end else begin
      d_s1   <= {req_s, req_m};
      d_s2   <= d_s1;
      d_prev <= d_s2;
      for (int i = 0; i < 2; i++) begin
        if (d_s2[i] && !d_prev[i]) d_pulses[i] <= d_pulses[i] + 1;
      end
    end
  end

  // Running counts of request rises and overflow pulses.
  always @(negedge clk) begin
    req_prev_m <= req_m;
    if (req_m && !req_prev_m) rises_m <= rises_m + 1;
    if (ovf_m) ovf_cnt_m <= ovf_cnt_m + 1;
    if (ovf_s) ovf_cnt_s <= ovf_cnt_s + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_idle_m(input string tag, input int budget);
    int n = 0;
    while (busy_m && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy_m), 32'd0);
  endtask

  task automatic wait_idle_s(input string tag, input int budget);
    int n = 0;
    while (busy_s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy_s), 32'd0);
  endtask

  // Acknowledge by hand until the main instance has no work left.
  task automatic manual_drain(input string tag, input int budget);
    int n = 0;
    while ((busy_m || man_ack) && n < budget) begin
      if (req_m && !man_ack) man_ack = 1'b1;
      else if (!req_m && man_ack) man_ack = 1'b0;
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy_m), 32'd0);
  endtask

  initial begin
    int base_p, base_r, base_o, peak, highs;
    logic [SAT_CW-1:0] exp_sat [4];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3};

    rst_b = 1'b0; pulse_m = 1'b0; pulse_s = 1'b0;
    man_en = 1'b0; man_ack = 1'b0; sat_hold = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(req_m), 32'd0);
    check("rst_pend", 32'(pend_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_ovf", 32'(ovf_m), 32'd0);
    check("rst_pend_sat", 32'(pend_s), 32'd0);
`ifdef SYNC_REQ_TIMEOUT_EN
    check("rst_terr", 32'(terr_m), 32'd0);
`endif
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single event through the looped-back destination
    base_p = d_pulses[0];
    pulse_m = 1'b1;
    @(negedge clk);
    check("t1_pend1", 32'(pend_m), 32'd1);
    check("t1_req_lo", 32'(req_m), 32'd0);
    pulse_m = 1'b0;
    @(negedge clk);
    check("t1_req_hi", 32'(req_m), 32'd1);
    check("t1_busy", 32'(busy_m), 32'd1);
    wait_idle_m("t1_idle", 200);
    check("t1_ack_low_at_idle", 32'(ack_m), 32'd0);
    repeat (10) @(negedge clk);
    check("t1_pend0", 32'(pend_m), 32'd0);
    check("t1_dst_pulses", 32'(d_pulses[0] - base_p), 32'd1);

    // 2: burst of five consecutive events
    base_p = d_pulses[0]; base_r = rises_m; base_o = ovf_cnt_m; peak = 0;
    pulse_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (int'(pend_m) > peak) peak = int'(pend_m);
    end
    pulse_m = 1'b0;
    for (int k = 0; k < 3000 && busy_m; k++) begin
      @(negedge clk);
      if (int'(pend_m) > peak) peak = int'(pend_m);
    end
    check("t2_idle", 32'(busy_m), 32'd0);
    repeat (10) @(negedge clk);
    check("t2_peak", 32'(peak), 32'd5);
    check("t2_req_cycles", 32'(rises_m - base_r), 32'd5);
    check("t2_dst_pulses", 32'(d_pulses[0] - base_p), 32'd5);
    check("t2_no_ovf", 32'(ovf_cnt_m - base_o), 32'd0);

    // 3: saturation with a 2-bit counter while ack is held low
    base_p = d_pulses[1]; base_o = ovf_cnt_s;
    pulse_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_pend_step", 32'(pend_s), 32'(exp_sat[k]));
    end
    check("t3_ovf_hi", 32'(ovf_s), 32'd1);
    pulse_s = 1'b0;
    @(negedge clk);
    check("t3_ovf_lo", 32'(ovf_s), 32'd0);
    check("t3_pend_sat", 32'(pend_s), 32'd3);
    sat_hold = 1'b0;
    wait_idle_s("t3_idle", 2000);
    repeat (10) @(negedge clk);
    check("t3_ovf_once", 32'(ovf_cnt_s - base_o), 32'd1);
    check("t3_delivered", 32'(d_pulses[1] - base_p), 32'd3);
    check("t3_pend0", 32'(pend_s), 32'd0);
    sat_hold = 1'b1;

    // 4: event arriving in the commit cycle leaves the count unchanged
    man_en = 1'b1; man_ack = 1'b0;
    repeat (4) @(negedge clk);
    pulse_m = 1'b1;
    repeat (2) @(negedge clk);
    pulse_m = 1'b0;
    check("t4_pend2", 32'(pend_m), 32'd2);
    check("t4_req_hi", 32'(req_m), 32'd1);
    man_ack = 1'b1;
    repeat (AFN) @(negedge clk);
    check("t4_req_before_commit", 32'(req_m), 32'd1);
    pulse_m = 1'b1;
    @(negedge clk);
    pulse_m = 1'b0;
    check("t4_req_committed", 32'(req_m), 32'd0);
    check("t4_pend_same", 32'(pend_m), 32'd2);
    manual_drain("t4_drain", 500);

    // 5: reset while in ACK_HI with three events pending
    pulse_m = 1'b1;
    repeat (4) @(negedge clk);
    pulse_m = 1'b0;
    check("t5_pend4", 32'(pend_m), 32'd4);
    man_ack = 1'b1;
    repeat (AFN + 1) @(negedge clk);
    check("t5_pend3", 32'(pend_m), 32'd3);
    check("t5_req_lo", 32'(req_m), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    check("t5_rst_req", 32'(req_m), 32'd0);
    check("t5_rst_pend", 32'(pend_m), 32'd0);
    check("t5_rst_busy", 32'(busy_m), 32'd0);
    man_ack = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    highs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_m) highs++;
    end
    check("t5_req_quiet", 32'(highs), 32'd0);
    check("t5_pend_quiet", 32'(pend_m), 32'd0);

    // 6: ack stuck low after one event on the TO_WIDTH=4 instance
    pulse_s = 1'b1;
    @(negedge clk);
    pulse_s = 1'b0;
    @(negedge clk);
    check("t6_req_hi", 32'(req_s), 32'd1);
`ifdef SYNC_REQ_TIMEOUT_EN
    repeat (14) @(negedge clk);
    check("t6_terr_early", 32'(terr_s), 32'd0);
    @(negedge clk);
    check("t6_terr_set", 32'(terr_s), 32'd1);
    repeat (10) @(negedge clk);
    check("t6_terr_sticky", 32'(terr_s), 32'd1);
`else
    repeat (25) @(negedge clk);
`endif
    check("t6_req_held", 32'(req_s), 32'd1);
    check("t6_pend_held", 32'(pend_s), 32'd1);
    sat_hold = 1'b0;
    wait_idle_s("t6_idle", 2000);
    check("t6_pend0", 32'(pend_s), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_pulse2level_req.md
Name: sync_pulse2level_req

Overview:
Source-domain side of a 4-phase req/ack clock-domain-crossing handshake. It accepts single-cycle event pulses in the clk domain and counts them as pending. Each pending event is converted into one full req_out level cycle: raise, wait for ack high, drop, wait for ack low. Downstream, the destination domain receives req_out through sync_level2pulse, which yields one pulse per event; that block's sync_ack returns here as ack_in.

Parameters:
CNT_WIDTH, 4, width of the pending-event counter; max pending = 2^CNT_WIDTH-1.
ACK_FLOP_NUM, 3, synchronizer depth for ack_in; legal values are 2 or more.
TO_WIDTH, 8, timeout counter width; used only when SYNC_REQ_TIMEOUT_EN is defined.

Ports:
clk  input  1  source-domain clock.
rst_b  input  1  asynchronous active-low reset.
pulse_in  input  1  event pulse; each high cycle is one event.
ack_in  input  1  asynchronous ack level from the destination domain (destination sync_ack).
req_out  output  1  registered request level to the destination domain; glitch-free, driven directly from a flop.
busy  output  1  high when state != IDLE or pend_cnt != 0.
pend_cnt  output  CNT_WIDTH  number of events accepted but not yet acknowledged.
overflow  output  1  registered one-cycle pulse when an event is dropped.
timeout_err  output  1  sticky error flag; present only with SYNC_REQ_TIMEOUT_EN.

Behaviour:
- Reset: clock is clk; reset rst_b is asynchronous, active-low. During reset:
  - state = IDLE
  - req_out, pend_cnt, overflow, timeout_err = 0
  - ack synchronizer flops = 0
- ack_sync: ack_in passed through an ACK_FLOP_NUM-deep flop chain. The FSM only ever sees ack_sync.
- Pending counter, per cycle:
  - inc = pulse_in & (pend_cnt != max)
  - dec = commit, defined in the FSM below
  - pend_cnt += inc - dec
  - pulse_in and commit in the same cycle: net change is 0. This holds even when pend_cnt = max.
  - pulse_in with pend_cnt = max and no commit: event dropped; overflow = 1 on the next cycle.
- FSM states: IDLE, REQ, ACK_HI.
  - IDLE: if pend_cnt != 0, go to REQ and set req_out = 1 at the same edge.
  - REQ: wait for ack_sync == 1. Then commit (dec = 1), clear req_out to 0 and go to ACK_HI.
  - ACK_HI: wait for ack_sync == 0, then go to IDLE.
  - A new request is never raised while ack_sync is high. This guarantees exactly one destination pulse per event.
- Latency: pulse_in sampled high at edge N gives pend_cnt = 1 after edge N. req_out rises at edge N+1 when idle.
- Back-to-back events: req_out low time is at least ACK_FLOP_NUM+1 cycles, set by the ack_sync fall plus one IDLE cycle.
- ack_in high while in IDLE (spurious): ignored. The FSM does not leave IDLE on ack; only pend_cnt != 0 starts a request.
- Reset mid-handshake: req_out drops immediately. The destination must be reset in the same reset domain; partial events are lost by design.

Optional Feature:
Macro SYNC_REQ_TIMEOUT_EN.
- Defined:
  - A TO_WIDTH-bit counter clears on entry to REQ or ACK_HI and increments each cycle in those states.
  - If it reaches all-ones before the state exits, timeout_err is set (sticky until reset).
  - The FSM keeps waiting; no forced recovery.
- Not defined: no counter is built, and the timeout_err port is absent.

Decomposition:
- Shared package sync_pkg: state encoding constants SYNC_ST_IDLE=2'd0, SYNC_ST_REQ=2'd1, SYNC_ST_ACK_HI=2'd2.
- Sub-module: instantiate the existing sync_level2level with SIGNAL_WIDTH=1 and FLOP_NUM=ACK_FLOP_NUM for the ack_in path. Do not build a new synchronizer.

Test Plan:
1. Single event, ack looped back through a destination sync_level2pulse on an async clock (dst clk ratio 1:1.7):
   - Stimulus: one pulse_in.
   - Required: req_out rises 1 cycle after pend_cnt=1; exactly one sync_out pulse at the destination; pend_cnt returns to 0; busy falls after ack_sync falls.
2. Burst of 5 consecutive pulse_in cycles:
   - Required: pend_cnt peaks at 5; 5 complete req_out cycles; 5 destination pulses; overflow never asserted.
3. Saturation, CNT_WIDTH=2, ack_in held 0, 4 pulses:
   - Required: pend_cnt = 3; overflow pulses exactly once, 1 cycle after the 4th pulse.
   - Then release ack: 3 events are delivered.
4. Simultaneous event and commit:
   - Stimulus: pend_cnt = 2; pulse_in in the same cycle REQ sees ack_sync = 1.
   - Required: pend_cnt stays 2.
5. Reset asserted while in ACK_HI with pend_cnt = 3:
   - Required: req_out = 0, pend_cnt = 0, state IDLE immediately.
   - After release, with no pulse_in, req_out stays 0.
6. With SYNC_REQ_TIMEOUT_EN, TO_WIDTH = 4:
   - Stimulus: ack_in stuck 0 after one event.
   - Required: timeout_err sets 15 cycles after REQ entry and stays set; req_out stays 1.
